// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared cache-bus payload types and arbiter constants for cbus_rr_arbiter.
// The optional CBUS_ARB_PERF_EN build uses PERF_CNT_W for its counters.
package cbus_rr_arbiter_pkg;

    localparam int unsigned CBUS_ARB_MAX_PORTS = 16;
    localparam int unsigned CBUS_ADDR_W        = 64;
    localparam int unsigned CBUS_DATA_W        = 64;
    localparam int unsigned CBUS_STRB_W        = 8;
    localparam int unsigned CBUS_ID_W          = 8;
    localparam int unsigned PERF_CNT_W         = 32;

    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd2,
        MLEN8  = 4'd3,
        MLEN16 = 4'd4
    } cbus_mlen_t;

    // 151-bit request payload
    typedef struct packed {
        logic                   valid;
        logic                   is_write;
        logic                   uncached;
        logic [CBUS_ID_W-1:0]   id;
        logic [CBUS_ADDR_W-1:0] addr;
        cbus_mlen_t             len;
        logic [CBUS_STRB_W-1:0] wstrb;
        logic [CBUS_DATA_W-1:0] wdata;
    } cbus_req_t;

    // 66-bit response payload
    typedef struct packed {
        logic                   ready;
        logic                   last;
        logic [CBUS_DATA_W-1:0] rdata;
    } cbus_resp_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Grant index width; a single port still needs one bit.
    function automatic int unsigned arb_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cbus_rr_arbiter_if.sv
// Bundle of upstream/downstream cbus signals around cbus_rr_arbiter.
// grant_cnt/stall_cnt exist only when CBUS_ARB_PERF_EN is defined.
interface cbus_rr_arbiter_if
    import cbus_rr_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_PORTS = 2,
    localparam int unsigned IDX_W     = arb_idx_w(NUM_PORTS)
) ();

    cbus_req_t              ireqs  [NUM_PORTS];
    cbus_resp_t             iresps [NUM_PORTS];
    cbus_req_t              oreq;
    cbus_resp_t             oresp;
    logic                   busy;
    logic [IDX_W-1:0]       grant_idx;
`ifdef CBUS_ARB_PERF_EN
    logic [NUM_PORTS-1:0][PERF_CNT_W-1:0] grant_cnt;
    logic [PERF_CNT_W-1:0]                stall_cnt;
`endif

    // Arbiter side
    modport slave (
        input  ireqs,
        input  oresp,
        output iresps,
        output oreq,
        output busy,
        output grant_idx
`ifdef CBUS_ARB_PERF_EN
        ,
        output grant_cnt,
        output stall_cnt
`endif
    );

    // Masters plus memory side
    modport master (
        output ireqs,
        output oresp,
        input  iresps,
        input  oreq,
        input  busy,
        input  grant_idx
`ifdef CBUS_ARB_PERF_EN
        ,
        input  grant_cnt,
        input  stall_cnt
`endif
    );

endinterface

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// Combinational requester pick: round-robin from rr_ptr_i, or lowest index
// when FIXED_PRIO is set.
module cbus_rr_arbiter_rr_pick
    import cbus_rr_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_PORTS  = 2,
    parameter  bit          FIXED_PRIO = 1'b0,
    localparam int unsigned IDX_W      = arb_idx_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] valid_i,
    input  logic [IDX_W-1:0]     rr_ptr_i,
    output logic                 any_c_o,
    output logic [IDX_W-1:0]     idx_c_o
);

    logic        found;
    int unsigned cand;

    // First valid port in scan order; the scan wraps N-1 back to 0.
    always_comb begin
        found   = 1'b0;
        cand    = 0;
        idx_c_o = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            cand = FIXED_PRIO ? k : (32'(rr_ptr_i) + k);
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            if (!found && valid_i[IDX_W'(cand)]) begin
                found   = 1'b1;
                idx_c_o = IDX_W'(cand);
            end
        end
    end

    assign any_c_o = |valid_i;

endmodule

// File: rtl/cbus_rr_arbiter.sv
// N-to-1 cbus arbiter with registered grant, burst locking and round-robin or
// fixed priority; define CBUS_ARB_PERF_EN to add grant/stall counters.
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 2,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    cbus_rr_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = arb_idx_w(NUM_PORTS);

    if (NUM_PORTS < 1 || NUM_PORTS > CBUS_ARB_MAX_PORTS) begin : g_bad_ports
        $error("cbus_rr_arbiter: NUM_PORTS out of range");
    end

    arb_state_t           state_q;
    logic [IDX_W-1:0]     grant_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [NUM_PORTS-1:0] valid_vec_c;
    logic                 pick_any_c;
    logic [IDX_W-1:0]     pick_idx_c;
    logic                 busy_c;
    logic                 done_c;

    always_comb begin
        valid_vec_c = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            valid_vec_c[i] = bus.ireqs[i].valid;
        end
    end

    cbus_rr_arbiter_rr_pick #(
        .NUM_PORTS  (NUM_PORTS),
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .valid_i  (valid_vec_c),
        .rr_ptr_i (rr_ptr_q),
        .any_c_o  (pick_any_c),
        .idx_c_o  (pick_idx_c)
    );

    assign busy_c = (state_q == ARB_BUSY);
    assign done_c = bus.oresp.ready && bus.oresp.last;

    // Grant is held until the downstream signals last; no mid-burst re-arbitration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_any_c) begin
                        state_q <= ARB_BUSY;
                        grant_q <= pick_idx_c;
                    end
                end
                ARB_BUSY: begin
                    if (done_c) begin
                        state_q  <= ARB_IDLE;
                        rr_ptr_q <= ((32'(grant_q) + 32'd1) >= NUM_PORTS) ? '0
                                                                         : grant_q + IDX_W'(1);
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_c;
    assign bus.grant_idx = grant_q;

    // Data path steers only through the locked grant; everything else reads zero.
    always_comb begin
        bus.oreq = busy_c ? bus.ireqs[grant_q] : '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            bus.iresps[i] = (busy_c && (grant_q == IDX_W'(i))) ? bus.oresp : '0;
        end
    end

`ifdef CBUS_ARB_PERF_EN
    logic [NUM_PORTS-1:0][PERF_CNT_W-1:0] grant_cnt_q;
    logic [PERF_CNT_W-1:0]                stall_cnt_q;
    logic                                 stall_c;

    // In IDLE nobody holds the grant, so any waiting requester is stalled.
    assign stall_c = busy_c ? |(valid_vec_c & ~(NUM_PORTS'(1) << grant_q))
                            : |valid_vec_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (!busy_c && pick_any_c) begin
                grant_cnt_q[pick_idx_c] <= grant_cnt_q[pick_idx_c] + PERF_CNT_W'(1);
            end
            if (stall_c) begin
                stall_cnt_q <= stall_cnt_q + PERF_CNT_W'(1);
            end
        end
    end

    assign bus.grant_cnt = grant_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Self-checking bench for cbus_rr_arbiter: round-robin x4, fixed-priority x4 and
// single-port instances against an abstract ownership model.
module tb_cbus_rr_arbiter;
    import cbus_rr_arbiter_pkg::*;

    localparam int ND = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cbus_req_t  req_drv [4];
    cbus_resp_t resp_drv;

    cbus_rr_arbiter_if #(.NUM_PORTS(4)) if_rr ();
    cbus_rr_arbiter_if #(.NUM_PORTS(4)) if_fp ();
    cbus_rr_arbiter_if #(.NUM_PORTS(1)) if_one ();

    assign if_rr.ireqs     = req_drv;
    assign if_fp.ireqs     = req_drv;
    assign if_one.ireqs[0] = req_drv[0];
    assign if_rr.oresp     = resp_drv;
    assign if_fp.oresp     = resp_drv;
    assign if_one.oresp    = resp_drv;

    cbus_rr_arbiter #(.NUM_PORTS(4), .FIXED_PRIO(1'b0)) u_rr  (.clk(clk), .reset(reset), .bus(if_rr));
    cbus_rr_arbiter #(.NUM_PORTS(4), .FIXED_PRIO(1'b1)) u_fp  (.clk(clk), .reset(reset), .bus(if_fp));
    cbus_rr_arbiter #(.NUM_PORTS(1), .FIXED_PRIO(1'b0)) u_one (.clk(clk), .reset(reset), .bus(if_one));

    // Reference model: who owns the bus (-1 = nobody) and where the next scan starts
    int np    [ND] = '{4, 4, 1};
    bit fp    [ND] = '{1'b0, 1'b1, 1'b0};
    int owner [ND];
    int ptr   [ND];
    bit prev_busy [ND];
`ifdef CBUS_ARB_PERF_EN
    logic [31:0] gcnt [ND][4];
    logic [31:0] scnt [ND];
`endif

    int n_checks = 0;
    int n_err    = 0;
    int gq_rr[$];
    int gq_fp[$];
    int beats_rr1 = 0;
    int lasts_rr1 = 0;
    int exp_rr [5] = '{0, 1, 2, 3, 0};
    int exp_fp [3] = '{1, 0, 3};

    task automatic chk(input string tag, input logic [150:0] obs, input logic [150:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic cbus_req_t rand_req(input logic v);
        cbus_req_t r;
        r.valid    = v;
        r.is_write = 1'($urandom);
        r.uncached = 1'($urandom);
        r.id       = 8'($urandom);
        r.addr     = {$urandom, $urandom};
        r.len      = cbus_mlen_t'($urandom_range(0, 4));
        r.wstrb    = 8'($urandom);
        r.wdata    = {$urandom, $urandom};
        return r;
    endfunction

    function automatic cbus_resp_t rand_resp(input logic rdy, input logic lst);
        cbus_resp_t r;
        r.ready = rdy;
        r.last  = lst;
        r.rdata = {$urandom, $urandom};
        return r;
    endfunction

    function automatic int pick(input int d, input logic [3:0] vm);
        for (int k = 0; k < np[d]; k++) begin
            int j;
            j = fp[d] ? k : (ptr[d] + k) % np[d];
            if (1'(vm >> j)) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            owner[d] = -1;
            ptr[d]   = 0;
`ifdef CBUS_ARB_PERF_EN
            scnt[d] = '0;
            for (int i = 0; i < 4; i++) gcnt[d][i] = '0;
`endif
        end
    endtask

    // What each arbiter should do at a clock edge, given the inputs it saw.
    task automatic model_edge(input logic [3:0] v, input logic rdy, input logic lst);
        for (int d = 0; d < ND; d++) begin
            logic [3:0] vm;
            int p;
            vm = v & 4'((1 << np[d]) - 1);
`ifdef CBUS_ARB_PERF_EN
            if (owner[d] < 0 ? (vm != 4'd0) : ((vm & ~4'(1 << owner[d])) != 4'd0))
                scnt[d] = scnt[d] + 32'd1;
`endif
            if (owner[d] < 0) begin
                p = pick(d, vm);
                if (p >= 0) begin
                    owner[d] = p;
`ifdef CBUS_ARB_PERF_EN
                    gcnt[d][p] = gcnt[d][p] + 32'd1;
`endif
                end
            end else if (rdy && lst) begin
                ptr[d]   = (owner[d] + 1) % np[d];
                owner[d] = -1;
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < ND; d++) begin
            logic       ob;
            int         og;
            cbus_req_t  oq;
            cbus_req_t  eq;
            cbus_resp_t er;
            cbus_resp_t ors [4];
`ifdef CBUS_ARB_PERF_EN
            logic [31:0] ogc [4];
            logic [31:0] osc;
`endif
            case (d)
                0: begin
                    ob = if_rr.busy; og = int'(if_rr.grant_idx); oq = if_rr.oreq;
                    for (int i = 0; i < 4; i++) ors[i] = if_rr.iresps[i];
`ifdef CBUS_ARB_PERF_EN
                    for (int i = 0; i < 4; i++) ogc[i] = if_rr.grant_cnt[i];
                    osc = if_rr.stall_cnt;
`endif
                end
                1: begin
                    ob = if_fp.busy; og = int'(if_fp.grant_idx); oq = if_fp.oreq;
                    for (int i = 0; i < 4; i++) ors[i] = if_fp.iresps[i];
`ifdef CBUS_ARB_PERF_EN
                    for (int i = 0; i < 4; i++) ogc[i] = if_fp.grant_cnt[i];
                    osc = if_fp.stall_cnt;
`endif
                end
                default: begin
                    ob = if_one.busy; og = int'(if_one.grant_idx); oq = if_one.oreq;
                    ors[0] = if_one.iresps[0];
                    for (int i = 1; i < 4; i++) ors[i] = '0;
`ifdef CBUS_ARB_PERF_EN
                    ogc[0] = if_one.grant_cnt[0];
                    for (int i = 1; i < 4; i++) ogc[i] = '0;
                    osc = if_one.stall_cnt;
`endif
                end
            endcase

            chk($sformatf("d%0d busy", d), 151'(ob), 151'(owner[d] >= 0));
            if (owner[d] >= 0)
                chk($sformatf("d%0d grant_idx", d), 151'(og), 151'(owner[d]));
            eq = (owner[d] >= 0) ? req_drv[owner[d]] : '0;
            chk($sformatf("d%0d oreq", d), 151'(oq), 151'(eq));
            for (int i = 0; i < np[d]; i++) begin
                er = (owner[d] == i) ? resp_drv : '0;
                chk($sformatf("d%0d iresps[%0d]", d, i), 151'(ors[i]), 151'(er));
            end
`ifdef CBUS_ARB_PERF_EN
            for (int i = 0; i < np[d]; i++)
                chk($sformatf("d%0d grant_cnt[%0d]", d, i), 151'(ogc[i]), 151'(gcnt[d][i]));
            chk($sformatf("d%0d stall_cnt", d), 151'(osc), 151'(scnt[d]));
`endif

            if (ob && !prev_busy[d]) begin
                if (d == 0) gq_rr.push_back(og);
                if (d == 1) gq_fp.push_back(og);
            end
            prev_busy[d] = ob;
            if (d == 0 && ors[1].ready) begin
                beats_rr1++;
                if (ors[1].last) lasts_rr1++;
            end
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic rdy, input logic lst);
        for (int i = 0; i < 4; i++) req_drv[i] = rand_req(1'(v >> i));
        resp_drv = rand_resp(rdy, lst);
    endtask

    // One cycle: drive, check settled outputs, clock, advance model.
    task automatic step(input logic [3:0] v, input logic rdy, input logic lst);
        drive(v, rdy, lst);
        #1;
        compare_all();
        @(posedge clk);
        model_edge(v, rdy, lst);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) req_drv[i] = '0;
        resp_drv = '0;
        for (int d = 0; d < ND; d++) prev_busy[d] = 1'b0;
        model_reset();

        // Reset state
        #1 reset = 1'b1;
        #2;
        compare_all();
        chk("rst grant_idx rr", 151'(if_rr.grant_idx), 151'(0));
        chk("rst grant_idx one", 151'(if_one.grant_idx), 151'(0));
        #9 reset = 1'b0;

        // Round-robin fairness with single-beat transactions
        for (int s = 0; s < 10; s++) step(4'b1111, 1'b1, 1'b1);
        chk("rr grant count", 151'(gq_rr.size()), 151'(5));
        for (int i = 0; i < 5; i++)
            chk($sformatf("rr order %0d", i), 151'((i < gq_rr.size()) ? gq_rr[i] : -1), 151'(exp_rr[i]));

        // Fixed priority: port 0 joins mid-burst and must wait
        gq_fp.delete();
        step(4'b1010, 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) step(4'b1011, 1'b1, 1'b0);
        step(4'b1011, 1'b1, 1'b1);
        step(4'b1001, 1'b0, 1'b0);
        step(4'b1001, 1'b1, 1'b1);
        step(4'b1000, 1'b0, 1'b0);
        step(4'b1000, 1'b1, 1'b1);
        chk("fp grant count", 151'(gq_fp.size()), 151'(3));
        for (int i = 0; i < 3; i++)
            chk($sformatf("fp order %0d", i), 151'((i < gq_fp.size()) ? gq_fp[i] : -1), 151'(exp_fp[i]));

        // Early drop: port 2 releases valid after beat 3 but stays locked
        step(4'b0100, 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) step(4'b0100, 1'b1, 1'b0);
        for (int s = 0; s < 4; s++) step(4'b0000, 1'b1, 1'b0);
        chk("drop oreq.valid", 151'(if_rr.oreq.valid), 151'(0));
        chk("drop locked idx", 151'(if_rr.grant_idx), 151'(2));
        step(4'b0000, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 1'b0);

        // Single 16-beat request from port 1
        beats_rr1 = 0;
        lasts_rr1 = 0;
        step(4'b0010, 1'b0, 1'b0);
        for (int s = 0; s < 15; s++) step(4'b0010, 1'b1, 1'b0);
        step(4'b0010, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 1'b0);
        chk("single beats", 151'(beats_rr1), 151'(16));
        chk("single lasts", 151'(lasts_rr1), 151'(1));

        // Reset on beat 5 of a port-2 burst, with rr_ptr already advanced
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0010, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        for (int s = 0; s < 4; s++) step(4'b0100, 1'b1, 1'b0);
        drive(4'b0100, 1'b1, 1'b0);
        #1;
        compare_all();
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1 reset = 1'b0;
        gq_rr.delete();
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b1);
        chk("post-reset first grant", 151'((gq_rr.size() > 0) ? gq_rr[0] : -1), 151'(0));

`ifdef CBUS_ARB_PERF_EN
        // Counter wrap from all-ones
        force u_rr.grant_cnt_q = '1;
        force u_rr.stall_cnt_q = '1;
        #1;
        release u_rr.grant_cnt_q;
        release u_rr.stall_cnt_q;
        for (int i = 0; i < 4; i++) gcnt[0][i] = 32'hFFFF_FFFF;
        scnt[0] = 32'hFFFF_FFFF;
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0010, 1'b1, 1'b1);
        chk("wrap grant_cnt[1]", 151'(if_rr.grant_cnt[1]), 151'(0));
        chk("wrap stall_cnt", 151'(if_rr.stall_cnt), 151'(0));
`endif

        // Random traffic
        for (int s = 0; s < 400; s++)
            step(4'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cbus_rr_arbiter.md
Name: cbus_rr_arbiter

Overview:
- Parametrised N-to-1 arbiter on the simplified burst cache bus (cbus_req_t / cbus_resp_t); merges N cache masters (ICache, DCache, uncached bridge, page-table walker) onto one memory-side cbus.
- Supersedes the fixed 2-port, combinationally selected arbiter: adds a port-count parameter, round-robin or fixed-priority mode, registered grant, and per-transaction locking.

Parameters:
- NUM_PORTS, 2, number of upstream masters, legal range 1..16.
- FIXED_PRIO, 0, 0 = round-robin; 1 = fixed priority, lowest index wins.
- IDX_W, $clog2(NUM_PORTS) (minimum 1), grant index width; derived, not overridden.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ireqs  in  NUM_PORTS x cbus_req_t (151 b each)  upstream requests.
- iresps  out  NUM_PORTS x cbus_resp_t (66 b each)  upstream responses.
- oreq  out  cbus_req_t  downstream request.
- oresp  in  cbus_resp_t  downstream response.
- busy  out  1  a transaction is granted and in flight.
- grant_idx  out  IDX_W  index of the granted port; valid while busy.

Behaviour:
- Reset values (async, immediate): state IDLE, oreq '0, all iresps '0, busy 0, grant_idx 0, rr_ptr 0.
- State IDLE:
  - oreq '0 and all iresps '0.
  - If any ireqs[i].valid, the chosen index is registered: next cycle is BUSY with grant_idx = choice.
  - Grant latency is 1 cycle from valid to oreq.valid.
- Selection:
  - FIXED_PRIO=0: first valid port scanning rr_ptr, rr_ptr+1, …, wrapping N-1 to 0.
  - FIXED_PRIO=1: lowest valid index; rr_ptr is ignored.
- State BUSY:
  - oreq = ireqs[grant_idx] combinationally, all fields, including valid as currently driven.
  - iresps[grant_idx] = oresp; every other iresps = '0.
  - Non-granted requests are ignored and not queued; they keep valid asserted.
- Completion:
  - oresp.ready && oresp.last in BUSY ends the transaction: next cycle IDLE.
  - rr_ptr = (grant_idx+1) mod NUM_PORTS.
  - The earliest new grant is the IDLE cycle after that, so a 1-cycle bubble between transactions is required.
- A granted master must hold valid and all fields until last. If it drops valid early, oreq.valid drops too, but the arbiter stays locked BUSY until oresp last. No re-arbitration mid-burst.
- oresp.ready outside BUSY is ignored and not forwarded.
- NUM_PORTS=1: grant_idx is always 0 and rr_ptr stays 0; the 1-cycle grant latency still applies.
- Reset asserted mid-burst forces IDLE asynchronously. The downstream is reset by the same reset.

Optional Feature:
- CBUS_ARB_PERF_EN defined:
  - Adds output grant_cnt, NUM_PORTS x 32 b.
  - grant_cnt[i] increments by 1 on each IDLE→BUSY transition granting port i.
  - Wraps at 2^32 and resets to 0.
  - Adds output stall_cnt, 32 b: increments every cycle in which some non-granted port has valid=1 (including while IDLE the cycle before its grant).
- Undefined: neither port exists and no counter logic is generated.

Decomposition:
- Shared package (common): cbus_req_t, cbus_resp_t, and a new typedef arb_state_t enum {ARB_IDLE, ARB_BUSY}.
- Shared package: a constant CBUS_ARB_MAX_PORTS = 16.
- Sub-module rr_pick:
  - Combinational.
  - Inputs: NUM_PORTS-bit valid vector, rr_ptr, FIXED_PRIO.
  - Outputs: any and idx.
  - Separately testable.

Test Plan:
- Single request: NUM_PORTS=2; ireqs[1] read, addr 0x8000_0000, len MLEN16 → oreq.valid at cycle +1; iresps[1] receives 16 ready beats, last on the 16th; iresps[0] stays 0; busy drops the cycle after last.
- Round-robin fairness: NUM_PORTS=4, FIXED_PRIO=0; ports 0–3 valid continuously, single-beat transactions → grants 0,1,2,3,0; one idle cycle between each; never two consecutive grants to the same port.
- Fixed priority: FIXED_PRIO=1; ports 1 and 3 valid, port 0 joins during port 1's burst → grants go 1, 0, 3; port 0 does not preempt port 1 mid-burst.
- Locking and early drop: granted port 2 drops valid after beat 3 of MLEN8 → oreq.valid goes 0; the arbiter stays BUSY with grant_idx=2 until oresp.last, then returns to IDLE.
- Reset mid-burst: reset asserted on beat 5 → in the same cycle oreq=0, iresps=0, busy=0; after release, port 0 wins first (rr_ptr=0).
- CBUS_ARB_PERF_EN: 10 grants to port 1 and 3 to port 0 → grant_cnt[1]=10, grant_cnt[0]=3; stall_cnt equals the counted contended cycles; preload the counters via force to 0xFFFF_FFFF to check wrap to 0.
